// File: rtl/prefetch_unit.sv
// prefetch_unit: instruction prefetch queue with a single-outstanding
// instruction-bus master. Fetched {pc, instr} pairs are buffered in a
// DEPTH-entry circular queue and presented to decode from the head.
// A redirect flushes the queue and restarts fetch at the new address;
// any response still in flight for the old stream is drained and dropped.
// Optional feature macro: PREFETCH_STALL_CNT_EN enables the bus-wait
// cycle counter on stall_cycles (tied to zero when undefined).

package prefetch_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

module prefetch_unit
  import prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready,
  output logic [63:0] stall_cycles
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   req_addr_q, req_addr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // queue storage; contents only matter where count says an entry is live
  logic [63:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic          req_valid;
  logic          push;
  logic          pop;
  logic [63:0]   redirect_pc_aligned;

  assign req_valid           = (state_q != IDLE);
  assign redirect_pc_aligned = {redirect_pc[63:2], 2'b00};

  // push only a response that belongs to the current stream; redirect wins
  assign push = (state_q == REQ) && iresp.data_ok && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;

  // next-state, fetch address and queue bookkeeping
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    case (state_q)
      IDLE: begin
        if (!redirect_valid && (count_q < DEPTH_C)) begin
          state_d    = REQ;
          req_addr_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          // a response arriving with the redirect is simply dropped
          state_d = iresp.data_ok ? IDLE : DRAIN;
        end else if (iresp.data_ok) begin
          state_d    = IDLE;
          fetch_pc_d = fetch_pc_q + 64'd4;
        end
      end
      DRAIN: begin
        // stale request stays on the bus until its response shows up
        if (iresp.data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc_aligned;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // queue write port; the entry becomes visible the cycle after the push
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= req_addr_q;
      instr_mem[wr_ptr_q] <= iresp.data;
    end
  end

  assign ireq.valid = req_valid;
  assign ireq.addr  = req_addr_q;

  // head outputs read as zero while the queue is empty
  assign out_valid = (count_q != '0);
  assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : 64'd0;
  assign out_instr = out_valid ? instr_mem[rd_ptr_q] : 32'd0;

`ifdef PREFETCH_STALL_CNT_EN
  logic [63:0] stall_q, stall_d;

  // count cycles spent waiting on the bus; wraps naturally at 2^64
  always_comb begin
    stall_d = stall_q;
    if (req_valid && !iresp.data_ok) begin
      stall_d = stall_q + 64'd1;
    end
  end

  // stall counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 64'd0;
`endif

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed testbench for prefetch_unit with a small latency-programmable
// instruction-bus responder. Expected values are hand-derived constants.
module tb_prefetch_unit;
  import prefetch_pkg::*;

  logic        clk;
  logic        reset;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic [63:0] stall_cycles;

  // bus responder state
  logic        bus_ok;
  logic [31:0] bus_data;
  int          bus_lat;
  int          wait_cnt;
  logic        bad_data;

  int total;
  int bad;

  assign iresp.data_ok = bus_ok;
  assign iresp.data    = bus_data;

  prefetch_unit #(.DEPTH(4), .RESET_PC(64'h8000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq           (ireq),
    .iresp          (iresp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_ready      (out_ready),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_instr(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  // responder: data_ok after bus_lat waiting cycles of ireq.valid
  task automatic bus_model();
    if (!ireq.valid) begin
      bus_ok   = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= bus_lat) begin
      bus_ok   = 1'b1;
      bus_data = bad_data ? 32'hDEAD_BEEF : exp_instr(ireq.addr);
    end else begin
      bus_ok   = 1'b0;
      wait_cnt = wait_cnt + 1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    bus_model();
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    out_ready      = 1'b0;
    bad_data       = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    int          first_req;
    int          first_out;
    int          n;
    int          pushes;
    logic        done;
    logic [63:0] seen_pc [3];
    logic [63:0] exp_stall;

    total    = 0;
    bad      = 0;
    bus_ok   = 1'b0;
    bus_data = 32'd0;
    bus_lat  = 0;
    wait_cnt = 0;

    // ---- reset state
    do_reset();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_ireq_valid", 64'(ireq.valid), 64'd0);
    chk("rst_stall", stall_cycles, 64'd0);

    // ---- sequential stream, data_ok one cycle after request
    bus_lat   = 1;
    out_ready = 1'b1;
    reset     = 1'b0;
    first_req = -1;
    first_out = -1;
    n         = 0;
    for (int c = 1; c <= 60 && n < 3; c++) begin
      cyc();
      if (ireq.valid && first_req < 0) first_req = c;
      if (out_valid) begin
        if (first_out < 0) first_out = c;
        seen_pc[n] = out_pc;
        if (n == 0) chk("seq_instr0", 64'(out_instr), 64'(exp_instr(64'h8000_0000)));
        n++;
      end
    end
    chk("seq_count", 64'(n), 64'd3);
    chk("seq_latency", 64'(first_out - first_req), 64'd2);
    chk("seq_pc0", seen_pc[0], 64'h8000_0000);
    chk("seq_pc1", seen_pc[1], 64'h8000_0004);
    chk("seq_pc2", seen_pc[2], 64'h8000_0008);

    // ---- fill with decode stalled, then a single pop
    do_reset();
    bus_lat = 0;
    reset   = 1'b0;
    pushes  = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (ireq.valid && bus_ok) pushes++;
    end
    chk("full_pushes", 64'(pushes), 64'd4);
    chk("full_no_req", 64'(ireq.valid), 64'd0);
    chk("full_head", out_pc, 64'h8000_0000);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("pop_head", out_pc, 64'h8000_0004);
    chk("pop_idle", 64'(ireq.valid), 64'd0);
    cyc();
    chk("refill_valid", 64'(ireq.valid), 64'd1);
    chk("refill_addr", ireq.addr, 64'h8000_0010);

    // ---- redirect while request pending, stale response drained
    do_reset();
    bus_lat  = 3;
    bad_data = 1'b1;
    reset    = 1'b0;
    cyc();
    chk("drain_req", 64'(ireq.valid), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1002;
    cyc();
    redirect_valid = 1'b0;
    chk("drain_hold_valid", 64'(ireq.valid), 64'd1);
    chk("drain_hold_addr", ireq.addr, 64'h8000_0000);
    cyc();
    chk("drain_wait_ok", 64'(bus_ok), 64'd0);
    cyc();
    chk("drain_resp_ok", 64'(bus_ok), 64'd1);
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    bad_data = 1'b0;
    bus_lat  = 0;
    cyc();
    chk("drain_idle", 64'(ireq.valid), 64'd0);
    chk("drain_no_dead", 64'(out_instr == 32'hDEAD_BEEF || out_valid), 64'd0);
    cyc();
    chk("drain_new_addr", ireq.addr, 64'h8000_1000);
    cyc();
    chk("drain_new_pc", out_pc, 64'h8000_1000);
    chk("drain_new_instr", 64'(out_instr), 64'(exp_instr(64'h8000_1000)));

    // ---- redirect coinciding with data_ok
    do_reset();
    bus_lat = 0;
    reset   = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("same_pre_valid", 64'(out_valid), 64'd1);
    chk("same_pre_ok", 64'(ireq.valid && bus_ok), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2000;
    cyc();
    redirect_valid = 1'b0;
    chk("same_flush", 64'(out_valid), 64'd0);
    chk("same_idle", 64'(ireq.valid), 64'd0);
    cyc();
    chk("same_new_addr", ireq.addr, 64'h8000_2000);
    cyc();
    chk("same_new_pc", out_pc, 64'h8000_2000);

    // ---- stall counter: two requests, five wait cycles each
    do_reset();
    bus_lat   = 5;
    out_ready = 1'b1;
    reset     = 1'b0;
    pushes    = 0;
    done      = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      cyc();
      if (ireq.valid && bus_ok) pushes++;
      if (pushes == 2) done = 1'b1;
    end
    chk("stall_done", 64'(done), 64'd1);
    cyc();
`ifdef PREFETCH_STALL_CNT_EN
    exp_stall = 64'd10;
`else
    exp_stall = 64'd0;
`endif
    chk("stall_cycles", stall_cycles, exp_stall);

    // ---- reset during DRAIN
    do_reset();
    bus_lat   = 100;
    out_ready = 1'b0;
    reset     = 1'b0;
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_3000;
    cyc();
    redirect_valid = 1'b0;
    chk("rdrain_valid", 64'(ireq.valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("rdrain_async_valid", 64'(ireq.valid), 64'd0);
    cyc();
    chk("rdrain_ireq", 64'(ireq.valid), 64'd0);
    chk("rdrain_out", 64'(out_valid), 64'd0);
    reset   = 1'b0;
    bus_lat = 0;
    cyc();
    chk("rdrain_restart_valid", 64'(ireq.valid), 64'd1);
    chk("rdrain_restart_addr", ireq.addr, 64'h8000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch queue entries; power of two, minimum 2.
REQ-002 SHALL have parameter RESET_PC, default 64'h8000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ireq  output  ibus_req_t  instruction bus request (valid, addr).
REQ-006 SHALL have port iresp  input  ibus_resp_t  instruction bus response (data_ok, data[31:0]).
REQ-007 SHALL have port redirect_valid  input  1  pipeline requests a fetch-stream change this cycle.
REQ-008 SHALL have port redirect_pc  input  64  new fetch address; bits [1:0] ignored, treated as zero.
REQ-009 SHALL have port out_valid  output  1  queue head holds a valid instruction.
REQ-010 SHALL have port out_pc  output  64  pc of the queue head.
REQ-011 SHALL have port out_instr  output  32  raw instruction of the queue head.
REQ-012 SHALL have port out_ready  input  1  decode accepts the head; pop occurs when out_valid & out_ready.
REQ-013 SHALL have port stall_cycles  output  64  bus-wait cycle count (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, REQ, DRAIN.
REQ-015 IDLE: SHALL issue a request (go to REQ, ireq.addr = fetch_pc) when queue count < DEPTH and no redirect this cycle.
REQ-016 REQ: SHALL hold ireq.valid=1 and ireq.addr stable until the cycle iresp.data_ok=1; at most one outstanding request.
REQ-017 REQ with data_ok and no redirect: SHALL push {fetch_pc, iresp.data}, advance fetch_pc by 4, return to IDLE.
REQ-018 Pushed entry SHALL appear on out_* the cycle after data_ok; no same-cycle bypass to out_*.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; a pop on a full queue plus a push SHALL be legal.
REQ-020 Count SHALL be $clog2(DEPTH)+1 bits; read/write pointers SHALL wrap modulo DEPTH.
REQ-021 Redirect SHALL have priority over push and pop: queue flushed (out_valid=0 next cycle), fetch_pc <= {redirect_pc[63:2],2'b00}.
REQ-022 Redirect in IDLE: SHALL stay IDLE; next request issues the following cycle at the new pc.
REQ-023 Redirect in REQ without data_ok: SHALL go to DRAIN, ireq held unchanged until data_ok.
REQ-024 Redirect in REQ with data_ok same cycle: response SHALL be discarded, state IDLE.
REQ-025 DRAIN: SHALL hold the stale request until data_ok, discard the response, then go IDLE; a further redirect in DRAIN SHALL update fetch_pc and stay in DRAIN.
REQ-026 ireq.valid SHALL be 1 exactly in REQ and DRAIN.

Reset
REQ-027 On reset: state=IDLE, fetch_pc=RESET_PC, queue empty, out_valid=0, out_pc=0, out_instr=0, ireq.valid=0, stall_cycles=0.
REQ-028 Reset asserted mid-request SHALL abandon the request immediately; the first post-reset request SHALL be to RESET_PC.

Configuration
REQ-029 Macro PREFETCH_STALL_CNT_EN defined: stall_cycles SHALL increment by 1 each cycle ireq.valid=1 and iresp.data_ok=0, wrapping at 2^64.
REQ-030 Macro PREFETCH_STALL_CNT_EN undefined: stall_cycles SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-031 Reset release, data_ok every cycle after request, out_ready=1 -> out_pc sequence 0x80000000, 0x80000004, 0x80000008, first out_valid 2 cycles after first ireq.valid.
REQ-032 DEPTH=4, out_ready=0, data_ok immediate -> exactly 4 pushes, ireq.valid stays 0 afterwards; one pop -> one new request at 0x80000010.
REQ-033 Redirect to 0x80001002 while REQ pending, data_ok 3 cycles later with 0xDEADBEEF -> 0xDEADBEEF never on out_instr; next ireq.addr=0x80001000.
REQ-034 Redirect same cycle as data_ok -> response discarded, queue empty next cycle, next request at redirect target.
REQ-035 PREFETCH_STALL_CNT_EN defined, data_ok delayed 5 cycles per request, 2 requests -> stall_cycles=10; undefined -> stall_cycles=0.
REQ-036 Assert reset during DRAIN -> next cycle ireq.valid=0, out_valid=0; after release first ireq.addr=RESET_PC.
